if_fetch_ctrl: RTL and testbench

- Sequences the instruction-fetch stage against an SRAM-like instruction bus (req/addr_ok/data_ok).
- Owns the fetch PC and allows at most one outstanding transaction.
- Applies exception/branch redirects and squashes stale returns.
- Presents a one-entry buffered {pc, inst} to ID under the hazard unit's stall.

---
 rtl/if_fetch_ctrl_pkg.sv | 15 +
 rtl/fetch_redirect.sv | 73 +++++++
 rtl/if_fetch_ctrl.sv | 143 ++++++++++++++
 tb/tb_if_fetch_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_ctrl_pkg.sv
// Shared types and defaults for the instruction-fetch controller.
package if_fetch_ctrl_pkg;

    localparam int unsigned ADDR_W_DEFAULT   = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        FetchIdle = 2'd0,
        FetchAddr = 2'd1,
        FetchData = 2'd2,
        FetchDrop = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_redirect.sv
// Redirect arbitration: except beats branch, and a pending target is held until the
// sequencer consumes it. A pending except is sticky against later branches.
module fetch_redirect
    import if_fetch_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              except_i,
    input  logic [ADDR_W-1:0] except_addr_i,
    input  logic              branch_i,
    input  logic [ADDR_W-1:0] branch_addr_i,
    input  logic              take_i,      // target is loaded into fetch_pc this cycle
    output logic              redirect_o,  // a redirect request arrives this cycle
    output logic              pending_o,   // a redirect is pending or arriving
    output logic [ADDR_W-1:0] target_o     // merged redirect target
);

    logic              pend_q, pend_d;
    logic              pend_exc_q, pend_exc_d;
    logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;
    logic              exc_held;

    assign exc_held   = pend_q && pend_exc_q;
    assign redirect_o = except_i || branch_i;
    assign pending_o  = pend_q || redirect_o;

    // Merge this cycle's request with the pending one, honouring priority.
    always_comb begin
        target_o = pend_tgt_q;
        if (except_i) begin
            target_o = except_addr_i;
        end else if (exc_held) begin
            target_o = pend_tgt_q;
        end else if (branch_i) begin
            target_o = branch_addr_i;
        end
    end

    // Next pending state: clear on consumption, otherwise capture new requests.
    always_comb begin
        pend_d     = pend_q;
        pend_exc_d = pend_exc_q;
        pend_tgt_d = pend_tgt_q;
        if (take_i) begin
            pend_d     = 1'b0;
            pend_exc_d = 1'b0;
        end else if (except_i) begin
            pend_d     = 1'b1;
            pend_exc_d = 1'b1;
            pend_tgt_d = except_addr_i;
        end else if (branch_i && !exc_held) begin
            pend_d     = 1'b1;
            pend_exc_d = 1'b0;
            pend_tgt_d = branch_addr_i;
        end
    end

    // Pending redirect register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_q     <= 1'b0;
            pend_exc_q <= 1'b0;
            pend_tgt_q <= '0;
        end else begin
            pend_q     <= pend_d;
            pend_exc_q <= pend_exc_d;
            pend_tgt_q <= pend_tgt_d;
        end
    end

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer: one outstanding req/addr_ok/data_ok transaction, redirect
// handling with stale-return squashing, and a one-entry {pc, inst} buffer toward ID.
module if_fetch_ctrl
    import if_fetch_ctrl_pkg::*;
#(
    parameter int unsigned        ADDR_W   = ADDR_W_DEFAULT,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              except,
    input  logic [ADDR_W-1:0] except_addr,
    input  logic              branch,
    input  logic [ADDR_W-1:0] branch_addr,
    output logic              inst_req,
    output logic [ADDR_W-1:0] inst_addr,
    input  logic              inst_addr_ok,
    input  logic              inst_data_ok,
    input  logic [ADDR_W-1:0] inst_rdata,
    output logic              if_valid,
    output logic [ADDR_W-1:0] if_pc,
    output logic [ADDR_W-1:0] if_inst,
    output logic              fetch_busy
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic              if_valid_q, if_valid_d;
    logic [ADDR_W-1:0] if_pc_q, if_pc_d;
    logic [ADDR_W-1:0] if_inst_q, if_inst_d;

    logic              redir_now;
    logic              redir_pending;
    logic [ADDR_W-1:0] redir_target;
    logic              redir_take;
    logic              buf_drain;

    fetch_redirect #(
        .ADDR_W (ADDR_W)
    ) u_redirect (
        .clk_i         (clk),
        .rst_ni        (rst),
        .except_i      (except),
        .except_addr_i (except_addr),
        .branch_i      (branch),
        .branch_addr_i (branch_addr),
        .take_i        (redir_take),
        .redirect_o    (redir_now),
        .pending_o     (redir_pending),
        .target_o      (redir_target)
    );

    assign buf_drain = if_valid_q && !stall;

    // Next-state, fetch PC and output-buffer update.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        if_valid_d = buf_drain ? 1'b0 : if_valid_q;
        if_pc_d    = if_pc_q;
        if_inst_d  = if_inst_q;
        redir_take = 1'b0;

        case (state_q)
            FetchIdle: begin
                if (redir_now) begin
                    redir_take = 1'b1;
                    fetch_pc_d = redir_target;
                    state_d    = FetchAddr;
                end else if (!if_valid_q || buf_drain) begin
                    state_d = FetchAddr;
                end
            end
            FetchAddr: begin
                // Request stays up until accepted; a redirect only marks it stale.
                if (inst_addr_ok) begin
                    state_d = redir_pending ? FetchDrop : FetchData;
                end
            end
            FetchData: begin
                if (inst_data_ok) begin
                    if (redir_now) begin
                        redir_take = 1'b1;
                        fetch_pc_d = redir_target;
                        state_d    = FetchAddr;
                    end else begin
                        if_valid_d = 1'b1;
                        if_pc_d    = fetch_pc_q;
                        if_inst_d  = inst_rdata;
                        fetch_pc_d = fetch_pc_q + ADDR_W'(4);
                        state_d    = buf_drain ? FetchAddr : FetchIdle;
                    end
                end else if (redir_now) begin
                    state_d = FetchDrop;
                end
            end
            FetchDrop: begin
                if (inst_data_ok) begin
                    redir_take = 1'b1;
                    fetch_pc_d = redir_target;
                    state_d    = FetchAddr;
                end
            end
            default: begin
                state_d = FetchAddr;
            end
        endcase

        // Any redirect invalidates the buffered instruction regardless of stall.
        if (redir_now) begin
            if_valid_d = 1'b0;
        end
    end

    // State, PC and buffer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= FetchAddr;
            fetch_pc_q <= RESET_PC;
            if_valid_q <= 1'b0;
            if_pc_q    <= '0;
            if_inst_q  <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            if_valid_q <= if_valid_d;
            if_pc_q    <= if_pc_d;
            if_inst_q  <= if_inst_d;
        end
    end

    // Bus and ID-side outputs are pure functions of registered state.
    always_comb begin
        inst_req   = (state_q == FetchAddr);
        inst_addr  = fetch_pc_q;
        if_valid   = if_valid_q;
        if_pc      = if_pc_q;
        if_inst    = if_inst_q;
        fetch_busy = (state_q != FetchIdle) && !if_valid_q;
    end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl with hand-computed expectations.
module tb_if_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        except;
    logic [31:0] except_addr;
    logic        branch;
    logic [31:0] branch_addr;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        fetch_busy;

    int checks = 0;
    int errors = 0;

    if_fetch_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .except       (except),
        .except_addr  (except_addr),
        .branch       (branch),
        .branch_addr  (branch_addr),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .if_valid     (if_valid),
        .if_pc        (if_pc),
        .if_inst      (if_inst),
        .fetch_busy   (fetch_busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; stall = 1'b0; except = 1'b0; branch = 1'b0;
        except_addr = '0; branch_addr = '0;
        inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = '0;
        step(); step();
        checks++; if (inst_req !== 1'b1) begin errors++;
            $display("FAIL reset_req got %b want 1", inst_req); end
        checks++; if (inst_addr !== 32'hBFC0_0000) begin errors++;
            $display("FAIL reset_addr got %h want bfc00000", inst_addr); end
        checks++; if (if_valid !== 1'b0) begin errors++;
            $display("FAIL reset_valid got %b want 0", if_valid); end
        checks++; if (if_pc !== 32'h0) begin errors++;
            $display("FAIL reset_pc got %h want 0", if_pc); end
        checks++; if (if_inst !== 32'h0) begin errors++;
            $display("FAIL reset_inst got %h want 0", if_inst); end
        checks++; if (fetch_busy !== 1'b1) begin errors++;
            $display("FAIL reset_busy got %b want 1", fetch_busy); end
        rst = 1'b1;
        step();
    endtask

    task automatic test_sequential();
        logic [31:0] exp_addr;
        logic [31:0] data;
        for (int i = 0; i < 3; i++) begin
            exp_addr = 32'hBFC0_0000 + 32'(4 * i);
            data     = 32'h1000_0000 + 32'(i);
            checks++; if (inst_req !== 1'b1 || inst_addr !== exp_addr) begin errors++;
                $display("FAIL seq_req%0d got %b/%h want 1/%h", i, inst_req, inst_addr, exp_addr); end
            step();
            inst_addr_ok = 1'b1;
            checks++; if (inst_addr !== exp_addr) begin errors++;
                $display("FAIL seq_hold%0d got %h want %h", i, inst_addr, exp_addr); end
            step();
            inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = data;
            step();
            inst_data_ok = 1'b0;
            checks++; if (if_valid !== 1'b1 || if_pc !== exp_addr || if_inst !== data) begin
                errors++;
                $display("FAIL seq_out%0d got %b/%h/%h want 1/%h/%h", i, if_valid, if_pc,
                         if_inst, exp_addr, data); end
            step();
            checks++; if (if_valid !== 1'b0) begin errors++;
                $display("FAIL seq_once%0d got %b want 0", i, if_valid); end
        end
    endtask

    task automatic test_stall();
        step();
        inst_addr_ok = 1'b1;
        step();
        inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'hABCD_0123;
        step();
        inst_data_ok = 1'b0; stall = 1'b1;
        checks++; if (fetch_busy !== 1'b0) begin errors++;
            $display("FAIL stall_busy got %b want 0", fetch_busy); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (if_valid !== 1'b1 || if_pc !== 32'hBFC0_000C || if_inst !== 32'hABCD_0123 ||
                inst_req !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold%0d got %b/%h/%h/%b want 1/bfc0000c/abcd0123/0", i,
                         if_valid, if_pc, if_inst, inst_req); end
            step();
        end
        stall = 1'b0;
        step();
        checks++; if (inst_req !== 1'b1 || inst_addr !== 32'hBFC0_0010 || if_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_next got %b/%h/%b want 1/bfc00010/0", inst_req, inst_addr,
                     if_valid); end
    endtask

    task automatic test_branch_addr_ok();
        inst_addr_ok = 1'b1; branch = 1'b1; branch_addr = 32'h8000_0100;
        step();
        inst_addr_ok = 1'b0; branch = 1'b0;
        checks++; if (inst_req !== 1'b0 || fetch_busy !== 1'b1) begin errors++;
            $display("FAIL drop_wait got %b/%b want 0/1", inst_req, fetch_busy); end
        inst_data_ok = 1'b1; inst_rdata = 32'hDEAD_BEEF;
        step();
        inst_data_ok = 1'b0;
        checks++; if (if_valid !== 1'b0 || inst_req !== 1'b1 || inst_addr !== 32'h8000_0100) begin
            errors++;
            $display("FAIL drop_target got %b/%b/%h want 0/1/80000100", if_valid, inst_req,
                     inst_addr); end
    endtask

    task automatic test_except_idle();
        step();
        inst_addr_ok = 1'b1;
        step();
        inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h1111_2222;
        step();
        inst_data_ok = 1'b0; stall = 1'b1;
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h8000_0100) begin errors++;
            $display("FAIL idle_buf got %b/%h want 1/80000100", if_valid, if_pc); end
        except = 1'b1; except_addr = 32'hBFC0_0380;
        branch = 1'b1; branch_addr = 32'h0000_1000;
        step();
        except = 1'b0; branch = 1'b0;
        checks++; if (inst_req !== 1'b1 || inst_addr !== 32'hBFC0_0380 || if_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_prio got %b/%h/%b want 1/bfc00380/0", inst_req, inst_addr,
                     if_valid); end
        stall = 1'b0;
    endtask

    task automatic test_pending_override();
        inst_addr_ok = 1'b1;
        step();
        inst_addr_ok = 1'b0; branch = 1'b1; branch_addr = 32'h0000_2000;
        step();
        branch = 1'b0; except = 1'b1; except_addr = 32'hBFC0_0200;
        step();
        except = 1'b0; branch = 1'b1; branch_addr = 32'h0000_3000;
        step();
        branch = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h5555_5555;
        step();
        inst_data_ok = 1'b0;
        checks++; if (inst_req !== 1'b1 || inst_addr !== 32'hBFC0_0200 || if_valid !== 1'b0) begin
            errors++;
            $display("FAIL pend_exc got %b/%h/%b want 1/bfc00200/0", inst_req, inst_addr,
                     if_valid); end
    endtask

    task automatic test_wrap();
        branch = 1'b1; branch_addr = 32'hFFFF_FFFC;
        step();
        branch = 1'b0;
        checks++; if (inst_req !== 1'b1 || inst_addr !== 32'hBFC0_0200) begin errors++;
            $display("FAIL addr_stable got %b/%h want 1/bfc00200", inst_req, inst_addr); end
        inst_addr_ok = 1'b1;
        step();
        inst_addr_ok = 1'b0; inst_data_ok = 1'b1;
        step();
        inst_data_ok = 1'b0;
        checks++; if (inst_addr !== 32'hFFFF_FFFC || if_valid !== 1'b0) begin errors++;
            $display("FAIL wrap_tgt got %h/%b want fffffffc/0", inst_addr, if_valid); end
        inst_addr_ok = 1'b1;
        step();
        inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'hCAFE_F00D;
        step();
        inst_data_ok = 1'b0;
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'hFFFF_FFFC || if_inst !== 32'hCAFE_F00D)
        begin
            errors++;
            $display("FAIL wrap_out got %b/%h/%h want 1/fffffffc/cafef00d", if_valid, if_pc,
                     if_inst); end
        step();
        checks++; if (inst_req !== 1'b1 || inst_addr !== 32'h0000_0000) begin errors++;
            $display("FAIL wrap_pc got %b/%h want 1/00000000", inst_req, inst_addr); end
    endtask

    task automatic test_data_redirect();
        inst_addr_ok = 1'b1;
        step();
        inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'hBAAD_BAAD;
        branch = 1'b1; branch_addr = 32'h0000_0102;
        step();
        inst_data_ok = 1'b0; branch = 1'b0;
        checks++; if (if_valid !== 1'b0 || inst_req !== 1'b1 || inst_addr !== 32'h0000_0102) begin
            errors++;
            $display("FAIL data_redir got %b/%b/%h want 0/1/00000102", if_valid, inst_req,
                     inst_addr); end
    endtask

    task automatic test_reset_mid();
        inst_addr_ok = 1'b1;
        step();
        inst_addr_ok = 1'b0;
        checks++; if (inst_req !== 1'b0) begin errors++;
            $display("FAIL mid_data got %b want 0", inst_req); end
        rst = 1'b0;
        #1;
        checks++; if (inst_req !== 1'b1 || inst_addr !== 32'hBFC0_0000 || if_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_async got %b/%h/%b want 1/bfc00000/0", inst_req, inst_addr,
                     if_valid); end
        step();
        rst = 1'b1; inst_data_ok = 1'b1; inst_rdata = 32'h0BAD_0BAD;
        step();
        inst_data_ok = 1'b0;
        checks++;
        if (if_valid !== 1'b0 || if_inst !== 32'h0 || inst_req !== 1'b1 ||
            inst_addr !== 32'hBFC0_0000 || fetch_busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_stray got %b/%h/%b/%h/%b want 0/0/1/bfc00000/1", if_valid,
                     if_inst, inst_req, inst_addr, fetch_busy); end
        step();
        checks++; if (if_valid !== 1'b0) begin errors++;
            $display("FAIL mid_late got %b want 0", if_valid); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_branch_addr_ok();
        test_except_idle();
        test_pending_override();
        test_wrap();
        test_data_redirect();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
